// File: rtl/mastermind_scoreboard.sv
// Mastermind scoreboard: per-game result history, guess counting, win/lose FSM and best score.
// Optional MASTERMIND_FLASH_EN builds a divider that blinks `flash` in WIN/LOSE.
module mastermind_scoreboard #(
  parameter int MAX_GUESSES = 8,
  parameter int FLASH_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       new_game,
  input  logic       result_valid,
  input  logic [2:0] red,
  input  logic [2:0] white,
  output logic       result_ready,
  output logic [3:0] guess_count,
  output logic       win,
  output logic       lose,
  output logic       err,
  output logic [3:0] best_score,
  input  logic [2:0] hist_sel,
  output logic [2:0] hist_red,
  output logic [2:0] hist_white,
  output logic       flash
);

  typedef enum logic [1:0] {PLAYING = 2'd0, WIN = 2'd1, LOSE = 2'd2} state_t;
  typedef struct packed {
    logic [2:0] red;
    logic [2:0] white;
  } entry_t;

  state_t       state, state_nxt;
  entry_t [7:0] hist;
  logic   [3:0] peg_sum;
  logic   [3:0] gc_inc;
  logic         malformed, accept, good;

  assign peg_sum   = {1'b0, red} + {1'b0, white};
  assign malformed = (red > 3'd4) || (peg_sum > 4'd4);
  // new_game has priority: a coincident result is dropped
  assign accept    = result_valid && (state == PLAYING) && !new_game;
  assign good      = accept && !malformed;
  assign gc_inc    = guess_count + 4'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= PLAYING;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (new_game)
      state_nxt = PLAYING;
    else if (good) begin
      if (red == 3'd4)                       state_nxt = WIN;
      else if (gc_inc == 4'(MAX_GUESSES))    state_nxt = LOSE;
    end
  end

  always_comb begin
    result_ready = (state == PLAYING);
    win          = (state == WIN);
    lose         = (state == LOSE);
  end

  // guess_count stays below MAX_GUESSES (<= 8) while PLAYING, so [2:0] indexes safely
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      guess_count <= '0;
      hist        <= '0;
      err         <= 1'b0;
      best_score  <= '0;
    end else if (new_game) begin
      guess_count <= '0;
      hist        <= '0;
      err         <= 1'b0;
    end else if (accept) begin
      if (malformed)
        err <= 1'b1;
      else begin
        hist[guess_count[2:0]] <= '{red: red, white: white};
        guess_count            <= gc_inc;
        if (red == 3'd4 && (best_score == 4'd0 || gc_inc < best_score))
          best_score <= gc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      {hist_red, hist_white} <= '0;
    else if ({1'b0, hist_sel} < guess_count)
      {hist_red, hist_white} <= hist[hist_sel];
    else
      {hist_red, hist_white} <= '0;
  end

`ifdef MASTERMIND_FLASH_EN
  logic [24:0] div_cnt;
  logic        flash_q;

  // Entry into WIN/LOSE starts a fresh high half-period
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
      flash_q <= 1'b0;
    end else if (state_nxt == PLAYING) begin
      div_cnt <= '0;
      flash_q <= 1'b0;
    end else if (state == PLAYING) begin
      div_cnt <= '0;
      flash_q <= 1'b1;
    end else if (div_cnt == 25'(FLASH_DIV - 1)) begin
      div_cnt <= '0;
      flash_q <= ~flash_q;
    end else
      div_cnt <= div_cnt + 25'd1;
  end

  assign flash = flash_q;
`else
  assign flash = win | lose;
`endif

endmodule

// File: tb/tb_mastermind_scoreboard.sv
// Scoreboard bench for mastermind_scoreboard: stimulus queues timed expectations, a negedge monitor checks them.
module tb_mastermind_scoreboard;
  logic       clk = 1'b0, resetn = 1'b0, new_game = 1'b0, result_valid = 1'b0;
  logic [2:0] red = '0, white = '0, hist_sel = '0;
  logic       result_ready, win, lose, err, flash;
  logic [3:0] guess_count, best_score;
  logic [2:0] hist_red, hist_white;

  mastermind_scoreboard #(.MAX_GUESSES(8), .FLASH_DIV(4)) dut (
    .clk(clk), .resetn(resetn), .new_game(new_game), .result_valid(result_valid),
    .red(red), .white(white), .result_ready(result_ready), .guess_count(guess_count),
    .win(win), .lose(lose), .err(err), .best_score(best_score), .hist_sel(hist_sel),
    .hist_red(hist_red), .hist_white(hist_white), .flash(flash)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef struct packed {
    int          cyc;
    logic [1:0]  kind;
    logic [11:0] val;
  } exp_t;
  exp_t  exp_q[$];
  string name_q[$];

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic exp_st(input int at, input string nm, input logic [3:0] gc, input logic w,
                        input logic l, input logic e, input logic [3:0] b, input logic rdy);
    exp_q.push_back('{at, 2'd0, {gc, w, l, e, b, rdy}});
    name_q.push_back(nm);
  endtask

  task automatic exp_hist(input int at, input string nm, input logic [2:0] r, input logic [2:0] w);
    exp_q.push_back('{at, 2'd1, {6'd0, r, w}});
    name_q.push_back(nm);
  endtask

  task automatic exp_flash(input int at, input string nm, input logic f);
    exp_q.push_back('{at, 2'd2, {11'd0, f}});
    name_q.push_back(nm);
  endtask

  // Monitor: compares every expectation due this cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d not checked, now %0d", nm, e.cyc, cyc);
      end else begin
        case (e.kind)
          2'd0:    check(nm, {guess_count, win, lose, err, best_score, result_ready}, e.val);
          2'd1:    check(nm, {6'd0, hist_red, hist_white}, e.val);
          default: check(nm, {11'd0, flash}, e.val);
        endcase
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [2:0] r, input logic [2:0] w);
    result_valid = 1'b1; red = r; white = w;
    @(posedge clk); #1;
    result_valid = 1'b0; red = '0; white = '0;
  endtask

  task automatic ng();
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
  endtask

  task automatic rb(input logic [2:0] s, input logic [2:0] r, input logic [2:0] w, input string nm);
    hist_sel = s;
    exp_hist(cyc + 1, nm, r, w);
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic f;
    // reset state
    @(posedge clk); #1;
    exp_st(cyc, "reset_st", 4'd0, 0, 0, 0, 4'd0, 1);
    exp_hist(cyc, "reset_hist", 3'd0, 3'd0);
    exp_flash(cyc, "reset_flash", 1'b0);
    idle(1);
    resetn = 1'b1;
    idle(1);

    // win in 3
    exp_st(cyc + 1, "a_g1", 4'd1, 0, 0, 0, 4'd0, 1); send(3'd1, 3'd2);
    exp_st(cyc + 1, "a_g2", 4'd2, 0, 0, 0, 4'd0, 1); send(3'd2, 3'd1);
    exp_st(cyc + 1, "a_win", 4'd3, 1, 0, 0, 4'd3, 0); send(3'd4, 3'd0);
    for (int i = 0; i < 9; i++) begin
`ifdef MASTERMIND_FLASH_EN
      f = (i < 4) || (i >= 8);
`else
      f = 1'b1;
`endif
      exp_flash(cyc, "a_flash", f);
      idle(1);
    end
    exp_st(cyc + 1, "a_ignored", 4'd3, 1, 0, 0, 4'd3, 0); send(3'd1, 3'd1);
    rb(3'd5, 3'd0, 3'd0, "a_rb5");
    rb(3'd2, 3'd4, 3'd0, "a_rb2");
    rb(3'd0, 3'd1, 3'd2, "a_rb0");
    rb(3'd1, 3'd2, 3'd1, "a_rb1");
    rb(3'd3, 3'd0, 3'd0, "a_rb3_edge");
    exp_st(cyc + 1, "ng1", 4'd0, 0, 0, 0, 4'd3, 1); ng();

    // lose after MAX_GUESSES
    hist_sel = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      exp_st(cyc + 1, "b_guess", 4'(i), 0, (i == 8), 0, 4'd3, (i != 8));
      if (i == 1) begin
        exp_hist(cyc + 1, "b_rb_old", 3'd0, 3'd0);
        exp_hist(cyc + 2, "b_rb_new", 3'd0, 3'd1);
      end
      send(3'd0, 3'd1);
    end
    exp_flash(cyc, "b_flash_lose", 1'b1);
    for (int s = 0; s < 8; s++) rb(3'(s), 3'd0, 3'd1, "b_rb");
    hist_sel = 3'd0;
    exp_st(cyc + 1, "ng2", 4'd0, 0, 0, 0, 4'd3, 1);
    exp_hist(cyc + 1, "b_rb_preclear", 3'd0, 3'd1);
    exp_flash(cyc + 1, "ng2_flash", 1'b0);
    exp_hist(cyc + 2, "b_rb_cleared", 3'd0, 3'd0);
    ng();

    // malformed results
    exp_st(cyc + 1, "c_mal_sum", 4'd0, 0, 0, 1, 4'd3, 1); send(3'd3, 3'd2);
    exp_st(cyc + 1, "c_mal_red", 4'd0, 0, 0, 1, 4'd3, 1); send(3'd5, 3'd0);
    exp_st(cyc + 1, "c_mal_white", 4'd0, 0, 0, 1, 4'd3, 1); send(3'd0, 3'd5);
    exp_st(cyc + 1, "c_sum4_ok", 4'd1, 0, 0, 1, 4'd3, 1); send(3'd2, 3'd2);
    exp_st(cyc + 1, "c_ng_clr", 4'd0, 0, 0, 0, 4'd3, 1); ng();

    // best score across games
    for (int i = 1; i <= 4; i++) begin
      exp_st(cyc + 1, "d_g", 4'(i), 0, 0, 0, 4'd3, 1); send(3'd0, 3'd0);
    end
    exp_st(cyc + 1, "d_win5", 4'd5, 1, 0, 0, 4'd3, 0); send(3'd4, 3'd0);
    exp_st(cyc + 1, "d_ng", 4'd0, 0, 0, 0, 4'd3, 1); ng();
    exp_st(cyc + 1, "d_g1", 4'd1, 0, 0, 0, 4'd3, 1); send(3'd1, 3'd0);
    exp_st(cyc + 1, "d_win2", 4'd2, 1, 0, 0, 4'd2, 0); send(3'd4, 3'd0);

    // new_game collides with result_valid
    exp_st(cyc + 1, "e_ng", 4'd0, 0, 0, 0, 4'd2, 1); ng();
    new_game = 1'b1; result_valid = 1'b1; red = 3'd4; white = 3'd0;
    exp_st(cyc + 1, "e_collide", 4'd0, 0, 0, 0, 4'd2, 1);
    @(posedge clk); #1;
    new_game = 1'b0; result_valid = 1'b0; red = '0;
    hist_sel = 3'd0;
    exp_st(cyc + 1, "e_g1", 4'd1, 0, 0, 0, 4'd2, 1); send(3'd1, 3'd1);
    exp_hist(cyc + 1, "e_rb", 3'd1, 3'd1);
    idle(1);

    // asynchronous reset mid-game, no clock edge
    @(negedge clk); #1;
    resetn = 1'b0;
    #1;
    check("e_rst_st", {guess_count, win, lose, err, best_score, result_ready},
          {4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1});
    check("e_rst_hist", {6'd0, hist_red, hist_white}, 12'd0);
    check("e_rst_flash", {11'd0, flash}, 12'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(1);
    exp_st(cyc, "e_post", 4'd0, 0, 0, 0, 4'd0, 1);
    idle(1);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) idle(1);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mastermind_scoreboard.md
# mastermind_scoreboard

- Downstream of the Mastermind datapath; consumes each final red/white peg result.
- Stores a per-game history of results, counts guesses, and runs the win/lose game state machine.
- Keeps a best-score register across games.
- Provides registered history readback and a status flash for the HEX/LED display logic.

## Interface
Parameters
- MAX_GUESSES, 8: guesses per game before loss; legal range 2..8.
- FLASH_DIV, 25000000: clock cycles per flash half-period; used only with MASTERMIND_FLASH_EN.

Ports
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- new_game  in  1  one-cycle pulse: abandon the current game and start a fresh one.
- result_valid  in  1  one-cycle pulse: red/white hold a final result.
- red  in  3  red peg count, 0..4.
- white  in  3  white peg count, 0..4.
- result_ready  out  1  high when a result can be accepted (state PLAYING).
- guess_count  out  4  accepted guesses this game, 0..MAX_GUESSES.
- win  out  1  game won.
- lose  out  1  game lost.
- err  out  1  sticky flag: a malformed result was received.
- best_score  out  4  fewest guesses in any won game since reset; 0 = no win yet.
- hist_sel  in  3  history entry to read back.
- hist_red  out  3  red count of the selected entry, registered.
- hist_white  out  3  white count of the selected entry, registered.
- flash  out  1  display blink/highlight.

## Operation
States: PLAYING, WIN, LOSE.
- Reset enters PLAYING.
- On reset, every output is 0 except result_ready, which is 1.
- On reset, all history entries clear to {0,0}.

Accept condition: result_valid=1 and state PLAYING.
- A result is malformed if red>4, or red+white>4 (sum computed in 4 bits).
- Malformed result: discarded and not counted; err set (sticky); state unchanged.
- Well-formed result: history[guess_count] <= {red,white}; guess_count increments.
- If red==4: go to WIN. If best_score==0 or new count < best_score, best_score <= new count.
- Else if new count == MAX_GUESSES: go to LOSE.
- Otherwise stay in PLAYING.

WIN and LOSE:
- result_ready=0; result_valid is ignored.
- guess_count and history are frozen.

new_game, from any state:
- Goes to PLAYING.
- Clears guess_count, history, err, win and lose.
- Keeps best_score.
- If new_game and result_valid arrive in the same cycle, new_game wins and the result is dropped.

Outputs:
- win = (state==WIN); lose = (state==LOSE); result_ready = (state==PLAYING).
- Readback: if hist_sel < guess_count, return the stored entry; otherwise return {0,0}.

## Timing
- Accepted result: guess_count, history, win/lose, best_score and err all update at the same clock edge, so they are visible the cycle after the pulse.
- result_ready drops the cycle after the accepting edge. No back-to-back issue exists, because the upstream stage produces at most one result per guess.
- Readback latency is 1 cycle: hist_red/hist_white reflect hist_sel and the stored data sampled at the previous edge.
- Writing the entry that hist_sel currently points to shows the new value 2 cycles after the result_valid pulse.
- Asserting resetn mid-game clears all state immediately, including best_score.
- new_game takes effect at the next edge; win/lose are low the following cycle.

## Configuration
- MASTERMIND_FLASH_EN defined:
  - A 25-bit divider runs only in WIN or LOSE; it is cleared on entry to either state and in PLAYING.
  - flash toggles every FLASH_DIV cycles, starting high on the first cycle in WIN/LOSE.
  - flash is 0 in PLAYING.
- MASTERMIND_FLASH_EN undefined:
  - No divider is built.
  - flash = win | lose, combinational from the state register.

## Test plan
- Reset, then results (1,2), (2,1), (4,0) → guess_count=3, win=1 one cycle after the third pulse, best_score=3, result_ready=0. A further result_valid leaves guess_count=3.
- MAX_GUESSES=8, eight results of (0,1) → lose=1 after the eighth, guess_count=8. Readback hist_sel=0..7 returns (0,1) with 1-cycle latency; readback after new_game returns (0,0).
- Malformed (3,2) then (5,0) → err=1, guess_count unchanged at 0. new_game → err=0.
- Win in 3 guesses, new_game, then win in 5 → best_score stays 3. new_game, then win in 2 → best_score=2.
- new_game in the same cycle as result_valid (4,0) → win=0, guess_count=0. resetn pulsed low mid-game without a clock edge → all outputs 0 immediately and result_ready=1.
- With MASTERMIND_FLASH_EN and FLASH_DIV=4 → after a win, flash reads 1,1,1,1,0,0,0,0,1… per cycle. With the macro undefined → flash constant 1.
